tlul_host_adapter: RTL and testbench



---
 rtl/tlul_host_adapter.sv | 175 +++++++++++++++++
 tb/tb_tlul_host_adapter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_host_adapter.sv
// TL-UL initiator adapter: host req/gnt port to TL-UL A channel, D responses
// back to the host as in-order rvalid/rdata/err with rotating source IDs.
package tlul_pkg;
  parameter int unsigned TL_AW  = 32;
  parameter int unsigned TL_DW  = 32;
  parameter int unsigned TL_AIW = 8;
  parameter int unsigned TL_DIW = 1;
  parameter int unsigned TL_AUW = 16;
  parameter int unsigned TL_DUW = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [1:0]          a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DW/8-1:0]  a_mask;
    logic [TL_DW-1:0]    a_data;
    logic [TL_AUW-1:0]   a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [1:0]          d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic [TL_DUW-1:0]   d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrW          = 32,
  parameter int unsigned DataW          = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [AddrW-1:0]   addr_i,
  input  logic               we_i,
  input  logic [DataW-1:0]   wdata_i,
  input  logic [DataW/8-1:0] be_i,
  output logic               rvalid_o,
  output logic [DataW-1:0]   rdata_o,
  output logic               err_o,
  output logic               unexp_rsp_o,
  output tl_h2d_t            tl_o,
  input  tl_d2h_t            tl_i
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [PtrW-1:0]           iss_ptr_q, iss_ptr_d;
  logic [PtrW-1:0]           ret_ptr_q, ret_ptr_d;
  logic [MaxOutstanding-1:0] exp_we_q, exp_we_d;
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [DataW-1:0]          rdata_q, rdata_d;
  logic                      unexp_q, unexp_d;

  logic             a_valid, gnt, d_ack, rsp_ok, head_we, rsp_err;
  logic [TL_AW-1:0] a_addr;

  always_comb begin
    a_valid = req_i & (cnt_q != CntMax) & ~rst_i;
    gnt     = a_valid & tl_i.a_ready;

    a_addr = '0;
    a_addr[AddrW-1:0] = {addr_i[AddrW-1:2], 2'b00};

    tl_o = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = !we_i ? Get : ((&be_i) ? PutFullData : PutPartialData);
    tl_o.a_size    = 2'd2;
    tl_o.a_source[PtrW-1:0] = iss_ptr_q;
    tl_o.a_address = a_addr;
    tl_o.a_mask    = we_i ? be_i : '1;
    tl_o.a_data    = we_i ? wdata_i : '0;
    tl_o.d_ready   = ~rst_i;
  end

  // d_ready mirrors ~rst_i, so every beat out of reset is acked on arrival.
  always_comb begin
    d_ack   = tl_i.d_valid & ~rst_i;
    rsp_ok  = d_ack & (cnt_q != '0);
    head_we = exp_we_q[ret_ptr_q];
    rsp_err = tl_i.d_error
            | (tl_i.d_source != TL_AIW'(ret_ptr_q))
            | (head_we  & (tl_i.d_opcode == AccessAckData))
            | (~head_we & (tl_i.d_opcode == AccessAck));
  end

  always_comb begin
    iss_ptr_d = iss_ptr_q;
    ret_ptr_d = ret_ptr_q;
    exp_we_d  = exp_we_q;
    cnt_d     = cnt_q;

    if (gnt) begin
      exp_we_d[iss_ptr_q] = we_i;
      iss_ptr_d = (iss_ptr_q == PtrMax) ? '0 : iss_ptr_q + PtrW'(1);
    end
    if (rsp_ok) begin
      ret_ptr_d = (ret_ptr_q == PtrMax) ? '0 : ret_ptr_q + PtrW'(1);
    end

    unique case ({gnt, rsp_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    rvalid_d = rsp_ok;
    err_d    = rsp_ok & rsp_err;
    rdata_d  = (rsp_ok & ~head_we & ~rsp_err) ? tl_i.d_data : '0;
    unexp_d  = d_ack & (cnt_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      iss_ptr_q <= '0;
      ret_ptr_q <= '0;
      exp_we_q  <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      unexp_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      iss_ptr_q <= iss_ptr_d;
      ret_ptr_q <= ret_ptr_d;
      exp_we_q  <= exp_we_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      unexp_q   <= unexp_d;
    end
  end

  assign gnt_o       = gnt;
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign unexp_rsp_o = unexp_q;

  logic unused_tl;
  assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, addr_i[1:0]};

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter: a queue-based model of the in-flight
// requests is checked every cycle, plus literal expectations per scenario.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        a_ready = 1'b1;
  logic        d_valid = 1'b0;
  tl_d_op_e    d_op = AccessAck;
  logic [7:0]  d_src = '0;
  logic [31:0] d_data = '0;
  logic        d_err = 1'b0;

  logic        gnt_o, rvalid_o, err_o, unexp_rsp_o;
  logic [31:0] rdata_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  always_comb begin
    tl_i = '0;
    tl_i.d_valid  = d_valid;
    tl_i.d_opcode = d_op;
    tl_i.d_source = d_src;
    tl_i.d_data   = d_data;
    tl_i.d_error  = d_err;
    tl_i.a_ready  = a_ready;
  end

  tlul_host_adapter #(.MaxOutstanding(MAX), .AddrW(32), .DataW(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_o), .addr_i(addr),
    .we_i(we), .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .unexp_rsp_o(unexp_rsp_o),
    .tl_o(tl_o), .tl_i(tl_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a FIFO of in-flight requests (source ID, write flag).
  typedef struct { int src; bit we; } ent_t;
  ent_t q[$];
  int   m_iss = 0;
  bit   chk_en = 0;
  bit   e_rvalid = 0, e_unexp = 0, e_err = 0;
  logic [31:0] e_rdata = '0;

  always @(negedge clk) begin
    bit   ev, eg;
    ent_t h;
    logic [3:0] emask;
    tl_a_op_e   eop;
    ev = req && (q.size() < MAX) && !rst;
    eg = ev && a_ready;
    if (chk_en) begin
      chk("rvalid", rvalid_o, e_rvalid);
      chk("unexp", unexp_rsp_o, e_unexp);
      if (e_rvalid) begin
        chk("err", err_o, e_err);
        chk("rdata", rdata_o, e_rdata);
      end
      chk("a_valid", tl_o.a_valid, ev);
      chk("gnt", gnt_o, eg);
      chk("d_ready", tl_o.d_ready, !rst);
      if (ev) begin
        eop   = !we ? Get : (be == 4'hF ? PutFullData : PutPartialData);
        emask = we ? be : 4'hF;
        chk("a_opcode", tl_o.a_opcode, eop);
        chk("a_address", tl_o.a_address, {addr[31:2], 2'b00});
        chk("a_mask", tl_o.a_mask, emask);
        chk("a_data", tl_o.a_data, we ? wdata : 32'h0);
        chk("a_source", tl_o.a_source, m_iss);
        chk("a_size", tl_o.a_size, 2);
      end
    end
    e_rvalid = 0; e_unexp = 0; e_err = 0; e_rdata = '0;
    if (rst) begin
      q.delete();
      m_iss = 0;
    end else begin
      if (d_valid) begin
        if (q.size() == 0) e_unexp = 1;
        else begin
          h = q.pop_front();
          e_rvalid = 1;
          e_err = d_err || (int'(d_src) != h.src) ||
                  (h.we ? (d_op == AccessAckData) : (d_op == AccessAck));
          e_rdata = (!h.we && !e_err) ? d_data : 32'h0;
        end
      end
      if (eg) begin
        q.push_back('{m_iss, we});
        m_iss = (m_iss + 1) % MAX;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] b, input int esrc, input tl_a_op_e eop,
                       input logic [31:0] eaddr, input logic [3:0] emask);
    bit got = 0;
    req = 1; addr = a; we = w; wdata = wd; be = b;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt_o) begin
        got = 1;
        chk("issue_src", tl_o.a_source, esrc);
        chk("issue_op", tl_o.a_opcode, eop);
        chk("issue_addr", tl_o.a_address, eaddr);
        chk("issue_mask", tl_o.a_mask, emask);
      end
      step();
    end
    chk("issue_granted", got, 1);
    req = 0;
  endtask

  task automatic respond(input int src, input tl_d_op_e op, input logic [31:0] data,
                         input logic e);
    d_valid = 1; d_src = 8'(src); d_op = op; d_data = data; d_err = e;
    step();
    d_valid = 0; d_err = 0;
  endtask

  task automatic expect_rsp(input string nm, input logic e, input logic [31:0] rd);
    chk({nm, "_rvalid"}, rvalid_o, 1);
    chk({nm, "_err"}, err_o, e);
    chk({nm, "_rdata"}, rdata_o, rd);
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    chk("rst_a_valid", tl_o.a_valid, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_d_ready", tl_o.d_ready, 0);
    step();
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_unexp", unexp_rsp_o, 0);
    req = 0;
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    step();
    chk_en = 1;
    do_reset();

    // single read
    issue(32'h1004, 0, 0, 4'h0, 0, Get, 32'h1004, 4'hF);
    respond(0, AccessAckData, 32'hDEADBEEF, 0);
    expect_rsp("rd", 0, 32'hDEADBEEF);

    // partial then full write
    issue(32'h2002, 1, 32'h12345678, 4'h3, 1, PutPartialData, 32'h2000, 4'h3);
    respond(1, AccessAck, 32'hFFFFFFFF, 0);
    expect_rsp("pwr", 0, 32'h0);
    issue(32'h2002, 1, 32'h12345678, 4'hF, 0, PutFullData, 32'h2000, 4'hF);
    respond(0, AccessAck, 32'h0, 0);
    expect_rsp("fwr", 0, 32'h0);

    // full stall with delayed responder
    do_reset();
    issue(32'h100, 0, 0, 4'h0, 0, Get, 32'h100, 4'hF);
    issue(32'h104, 0, 0, 4'h0, 1, Get, 32'h104, 4'hF);
    req = 1; addr = 32'h108; we = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_gnt", gnt_o, 0);
      step();
    end
    d_valid = 1; d_src = 8'd0; d_op = AccessAckData; d_data = 32'hA0;
    @(negedge clk);
    chk("stall_ack_gnt", gnt_o, 0);
    step();
    d_valid = 0;
    expect_rsp("stall0", 0, 32'hA0);
    @(negedge clk);
    chk("stall_free_gnt", gnt_o, 1);
    chk("stall_free_src", tl_o.a_source, 0);
    step();
    req = 0;
    respond(1, AccessAckData, 32'hA1, 0);
    expect_rsp("stall1", 0, 32'hA1);
    respond(0, AccessAckData, 32'hA2, 0);
    expect_rsp("stall2", 0, 32'hA2);

    // error paths
    issue(32'h500, 0, 0, 4'h0, 1, Get, 32'h500, 4'hF);
    respond(1, AccessAckData, 32'h1111, 1);
    expect_rsp("derr", 1, 32'h0);
    issue(32'h504, 1, 32'hCAFE, 4'hF, 0, PutFullData, 32'h504, 4'hF);
    respond(0, AccessAckData, 32'h2222, 0);
    expect_rsp("operr", 1, 32'h0);
    issue(32'h508, 0, 0, 4'h0, 1, Get, 32'h508, 4'hF);
    respond(0, AccessAckData, 32'h3333, 0);
    expect_rsp("srcerr", 1, 32'h0);
    issue(32'h50C, 0, 0, 4'h0, 0, Get, 32'h50C, 4'hF);
    respond(0, AccessAckData, 32'h55, 0);
    expect_rsp("srcadv", 0, 32'h55);

    // simultaneous grant and response with one in flight
    issue(32'h300, 0, 0, 4'h0, 1, Get, 32'h300, 4'hF);
    req = 1; addr = 32'h304; we = 1; be = 4'hF; wdata = 32'h0BAD;
    d_valid = 1; d_src = 8'd1; d_op = AccessAckData; d_data = 32'h77;
    @(negedge clk);
    chk("sim_gnt", gnt_o, 1);
    chk("sim_src", tl_o.a_source, 0);
    step();
    req = 0; d_valid = 0;
    expect_rsp("sim_rd", 0, 32'h77);
    respond(0, AccessAck, 32'h0, 0);
    expect_rsp("sim_wr", 0, 32'h0);
    issue(32'h308, 0, 0, 4'h0, 1, Get, 32'h308, 4'hF);
    respond(1, AccessAckData, 32'h99, 0);
    expect_rsp("sim_next", 0, 32'h99);

    // reset with two outstanding, then late beats
    issue(32'h400, 0, 0, 4'h0, 0, Get, 32'h400, 4'hF);
    issue(32'h404, 0, 0, 4'h0, 1, Get, 32'h404, 4'hF);
    req = 1; addr = 32'h40C;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      respond(s, AccessAckData, 32'hBEEF, 0);
      chk("late_unexp", unexp_rsp_o, 1);
      chk("late_rvalid", rvalid_o, 0);
    end
    issue(32'h408, 0, 0, 4'h0, 0, Get, 32'h408, 4'hF);
    respond(0, AccessAckData, 32'h4444, 0);
    expect_rsp("post_rst", 0, 32'h4444);

    // spurious beat at idle
    step();
    respond(0, AccessAck, 32'h0, 0);
    chk("idle_unexp", unexp_rsp_o, 1);
    chk("idle_rvalid", rvalid_o, 0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
